// File: rtl/max7219_pkg.sv
// Shared MAX7219 constants: register addresses, frame geometry and receiver FSM encoding.
package max7219_pkg;

    localparam int FRAME_BITS = 16;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [3:0] ADDR_NOOP   = 4'h0;
    localparam logic [3:0] ADDR_DIG0   = 4'h1;
    localparam logic [3:0] ADDR_DIG1   = 4'h2;
    localparam logic [3:0] ADDR_DIG2   = 4'h3;
    localparam logic [3:0] ADDR_DIG3   = 4'h4;
    localparam logic [3:0] ADDR_DIG4   = 4'h5;
    localparam logic [3:0] ADDR_DIG5   = 4'h6;
    localparam logic [3:0] ADDR_DIG6   = 4'h7;
    localparam logic [3:0] ADDR_DIG7   = 4'h8;
    localparam logic [3:0] ADDR_DECODE = 4'h9;
    localparam logic [3:0] ADDR_INTENS = 4'hA;
    localparam logic [3:0] ADDR_SCAN   = 4'hB;
    localparam logic [3:0] ADDR_SHDN   = 4'hC;
    localparam logic [3:0] ADDR_TEST   = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

    // Low 12 bits of a frame; D15:D12 are don't-care on the device.
    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } frame_t;

endpackage

// File: rtl/max7219_rx_if.sv
// MAX7219 serial bus: the driver side is master, the receiver/monitor is slave.
interface max7219_rx_if;

    logic max7219_din;
    logic max7219_ncs;
    logic max7219_clk;
    logic max7219_dout;

    modport master (
        output max7219_din,
        output max7219_ncs,
        output max7219_clk,
        input  max7219_dout
    );

    modport slave (
        input  max7219_din,
        input  max7219_ncs,
        input  max7219_clk,
        output max7219_dout
    );

endinterface

// File: rtl/max7219_edge_sync.sv
// Multi-flop synchronizer for one asynchronous pin plus single-cycle rise/fall pulses.
module max7219_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    // Stages [SYNC_STAGES-1:0] synchronize; the top bit is the one-cycle delay for edge detection.
    logic [SYNC_STAGES:0] sync_q;

    // NOTE: non-blocking assignments so every stage samples the previous stage's old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-1:0], pin};
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
    assign fall  = ~sync_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES];

endmodule

// File: rtl/max7219_rx.sv
// MAX7219 receive-side shadow: assembles 16-bit frames and decodes them into the register file.
// Optional daisy-chain output enabled by defining MAX7219_RX_DOUT_EN.
module max7219_rx
    import max7219_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,   // must be at least 2
    parameter logic [7:0] ROW_RESET   = 8'h00
) (
    input  logic         Clk_System,
    input  logic         lowRst_System,
    max7219_rx_if.slave  bus,
    output logic [7:0]   row0,
    output logic [7:0]   row1,
    output logic [7:0]   row2,
    output logic [7:0]   row3,
    output logic [7:0]   row4,
    output logic [7:0]   row5,
    output logic [7:0]   row6,
    output logic [7:0]   row7,
    output logic [7:0]   decode_mode,
    output logic [3:0]   intensity,
    output logic [2:0]   scan_limit,
    output logic         shutdown_n,
    output logic         disp_test,
    output logic         frame_valid,
    output logic [3:0]   frame_addr,
    output logic         frame_err
);

    logic din_s, din_rise, din_fall;
    logic ncs_s, ncs_rise, ncs_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic unused_sync;

    max7219_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
        .clk(Clk_System), .rst_n(lowRst_System), .pin(bus.max7219_din),
        .level(din_s), .rise(din_rise), .fall(din_fall)
    );

    max7219_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk(Clk_System), .rst_n(lowRst_System), .pin(bus.max7219_ncs),
        .level(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
    );

    max7219_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
        .clk(Clk_System), .rst_n(lowRst_System), .pin(bus.max7219_clk),
        .level(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    state_t                 state, state_next;
    logic                   start_frame, shift_en, latch_en;
    logic [FRAME_BITS-1:0]  shreg;
    logic [CNT_W-1:0]       bit_cnt;
    logic [7:0]             rows_q [8];
    frame_t                 frame;

    assign frame = frame_t'(shreg[11:0]);

    always_ff @(posedge Clk_System) begin
        if (!lowRst_System) state <= ST_IDLE;
        else                state <= state_next;
    end

    // NOTE: every output is given a default first so no path through the case infers a latch.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        shift_en    = 1'b0;
        latch_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ncs_fall) begin
                    state_next  = ST_SHIFT;
                    start_frame = 1'b1;
                end
            end
            ST_SHIFT: begin
                // A CLK edge in the same cycle as the nCS rise sees ncs_s high and is dropped.
                shift_en = sclk_rise & ~ncs_s;
                if (ncs_rise) state_next = ST_LATCH;
            end
            ST_LATCH: begin
                latch_en   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // NOTE: the register file is reset element by element; its contents are live outputs.
    always_ff @(posedge Clk_System) begin
        if (!lowRst_System) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            for (int i = 0; i < 8; i++) rows_q[i] <= ROW_RESET;
            decode_mode <= '0;
            intensity   <= '0;
            scan_limit  <= '0;
            shutdown_n  <= 1'b0;
            disp_test   <= 1'b0;
            frame_addr  <= ADDR_NOOP;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (start_frame) bit_cnt <= '0;
            if (shift_en) begin
                shreg <= {shreg[FRAME_BITS-2:0], din_s};
                if (bit_cnt != CNT_W'(FRAME_BITS)) bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (latch_en) begin
                if (bit_cnt == CNT_W'(FRAME_BITS)) begin
                    frame_valid <= 1'b1;
                    frame_addr  <= frame.addr;
                    case (frame.addr)
                        ADDR_DECODE: decode_mode <= frame.data;
                        ADDR_INTENS: intensity   <= frame.data[3:0];
                        ADDR_SCAN:   scan_limit  <= frame.data[2:0];
                        ADDR_SHDN:   shutdown_n  <= frame.data[0];
                        ADDR_TEST:   disp_test   <= frame.data[0];
                        default: begin
                            for (int i = 0; i < 8; i++) begin
                                if (frame.addr == ADDR_DIG0 + 4'(i)) rows_q[i] <= frame.data;
                            end
                        end
                    endcase
                end else if (bit_cnt != '0) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

    assign row0 = rows_q[0];
    assign row1 = rows_q[1];
    assign row2 = rows_q[2];
    assign row3 = rows_q[3];
    assign row4 = rows_q[4];
    assign row5 = rows_q[5];
    assign row6 = rows_q[6];
    assign row7 = rows_q[7];

`ifdef MAX7219_RX_DOUT_EN
    // Device behaviour: the bit leaving the shift register appears on DOUT at the CLK falling edge.
    logic dout_q;

    always_ff @(posedge Clk_System) begin
        if (!lowRst_System) begin
            dout_q <= 1'b0;
        end else if (state == ST_SHIFT && sclk_fall && !ncs_s) begin
            dout_q <= shreg[FRAME_BITS-1];
        end
    end

    assign bus.max7219_dout = dout_q;
    assign unused_sync      = ^{din_rise, din_fall, sclk_s};
`else
    assign bus.max7219_dout = 1'b0;
    assign unused_sync      = ^{din_rise, din_fall, sclk_s, sclk_fall, shreg[FRAME_BITS-1]};
`endif

endmodule

// File: tb/tb_max7219_rx.sv
// Directed bench for max7219_rx: a register-file model is compared against the DUT every cycle.
module tb_max7219_rx;
    import max7219_pkg::*;

    localparam int         SYNC    = 2;
    localparam logic [7:0] ROW_RST = 8'h3C;
    localparam int         HALF    = 4;   // system clocks per SCLK half period

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    max7219_rx_if bus ();

    logic [7:0][7:0] row_act;
    logic [7:0]      decode_mode;
    logic [3:0]      intensity;
    logic [2:0]      scan_limit;
    logic            shutdown_n, disp_test, frame_valid, frame_err;
    logic [3:0]      frame_addr;

    max7219_rx #(.SYNC_STAGES(SYNC), .ROW_RESET(ROW_RST)) dut (
        .Clk_System(clk), .lowRst_System(rst_n), .bus(bus),
        .row0(row_act[0]), .row1(row_act[1]), .row2(row_act[2]), .row3(row_act[3]),
        .row4(row_act[4]), .row5(row_act[5]), .row6(row_act[6]), .row7(row_act[7]),
        .decode_mode(decode_mode), .intensity(intensity), .scan_limit(scan_limit),
        .shutdown_n(shutdown_n), .disp_test(disp_test), .frame_valid(frame_valid),
        .frame_addr(frame_addr), .frame_err(frame_err)
    );

    int vectors     = 0;
    int miscompares = 0;
    bit chk_en      = 1'b0;

    // Model: a flat 16-entry register file indexed by address; outputs are views of it.
    logic [7:0] rf [16];
    logic [3:0] exp_addr;
    logic       exp_valid, exp_err;
    logic [15:0] dout_ref;

    function automatic logic [63:0] exp_rows();
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = rf[i+1];
        return r;
    endfunction

    function automatic logic [22:0] exp_ctrl();
        logic [7:0] intens_b, scan_b, shdn_b, test_b;
        intens_b = rf[10];
        scan_b   = rf[11];
        shdn_b   = rf[12];
        test_b   = rf[15];
        return {rf[9], intens_b[3:0], scan_b[2:0], shdn_b[0], test_b[0], exp_addr, exp_valid, exp_err};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) rf[i] = (i >= 1 && i <= 8) ? ROW_RST : 8'h00;
        exp_addr  = 4'h0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
    endtask

    task automatic model_frame(input logic [31:0] data, input int nbits);
        logic [15:0] w;
        w = data[15:0];
        if (nbits >= 16) begin
            rf[w[11:8]] = w[7:0];
            exp_addr    = w[11:8];
            exp_valid   = 1'b1;
        end else if (nbits > 0) begin
            exp_err = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rows", 64'(row_act), exp_rows());
            check("ctrl", 64'({decode_mode, intensity, scan_limit, shutdown_n, disp_test,
                               frame_addr, frame_valid, frame_err}), 64'(exp_ctrl()));
`ifndef MAX7219_RX_DOUT_EN
            check("dout_tied", 64'(bus.max7219_dout), 64'd0);
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_bits(input logic [31:0] data, input int nbits, input bit chk_dout);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.max7219_clk = 1'b0;
            bus.max7219_din = data[i];
            tick(HALF);
            if (chk_dout && (nbits - i) >= 17) begin
`ifdef MAX7219_RX_DOUT_EN
                check("dout", 64'(bus.max7219_dout), 64'(dout_ref[32 - (nbits - i)]));
`else
                check("dout", 64'(bus.max7219_dout), 64'd0);
`endif
            end
            bus.max7219_clk = 1'b1;
            tick(HALF);
        end
        bus.max7219_clk = 1'b0;
        tick(HALF);
    endtask

    task automatic send_frame(input logic [31:0] data, input int nbits, input bit chk_dout);
        bus.max7219_ncs = 1'b0;
        tick(HALF);
        shift_bits(data, nbits, chk_dout);
        bus.max7219_ncs = 1'b1;
        tick(SYNC + 2);
        model_frame(data, nbits);
        tick(1);
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        tick(HALF);
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        tick(1);
        model_reset();
        chk_en = 1'b1;
`ifdef MAX7219_RX_DOUT_EN
        check("dout_reset", 64'(bus.max7219_dout), 64'd0);
`endif
        tick(hold);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.max7219_ncs = 1'b1;
        bus.max7219_clk = 1'b0;
        bus.max7219_din = 1'b0;
        dout_ref        = 16'h0201;
        tick(2);
        do_reset(3);
        tick(4);
        check("reset_row3", 64'(row_act[3]), 64'(ROW_RST));
        check("reset_addr", 64'(frame_addr), 64'h0);

        send_frame(32'h0355, 16, 1'b0);
        check("row2_55", 64'(row_act[2]), 64'h55);
        check("addr_3",  64'(frame_addr), 64'h3);

        send_frame(32'h0A0F, 16, 1'b0);
        send_frame(32'h0B07, 16, 1'b0);
        send_frame(32'h0C01, 16, 1'b0);
        check("intens_F", 64'(intensity), 64'hF);
        check("scan_7",   64'(scan_limit), 64'h7);
        check("shdn_1",   64'(shutdown_n), 64'h1);

        send_frame(32'h01FF, 9, 1'b0);        // short frame: error pulse only
        check("row7_kept", 64'(row_act[7]), 64'(ROW_RST));
        send_frame(32'h0811, 16, 1'b0);
        check("row7_11", 64'(row_act[7]), 64'h11);

        send_frame(32'h00FF_0142, 24, 1'b0);  // only the last 16 bits count
        check("row0_42", 64'(row_act[0]), 64'h42);

        send_frame(32'h09F0, 16, 1'b0);
        send_frame(32'h0F01, 16, 1'b0);
        send_frame(32'h0D77, 16, 1'b0);       // unused address: pulse, no change
        check("addr_D", 64'(frame_addr), 64'hD);
        send_frame(32'h0, 0, 1'b0);           // nCS pulse with no clocks: silent

        // Reset in the middle of 0x0566, released with nCS still low.
        bus.max7219_ncs = 1'b0;
        tick(HALF);
        shift_bits(32'h05, 8, 1'b0);
        do_reset(4);
        tick(6);
        bus.max7219_ncs = 1'b1;
        tick(10);
        send_frame(32'h05AA, 16, 1'b0);
        check("row4_AA",  64'(row_act[4]), 64'hAA);
        check("row0_rst", 64'(row_act[0]), 64'(ROW_RST));

        send_frame(32'h0201_0000, 32, 1'b1);
        check("addr_noop", 64'(frame_addr), 64'h0);

        tick(4);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
